conv_layer_ctrl: RTL and testbench

- Sequencer for the first-layer convolution datapath: fifo_image_input line buffer feeding conv2d with 16 filters.
- On start, it reads 16 filter weight words and one bias word from parameter memory into the conv2d register bank.
- It then streams IMAGE_SIZE×IMAGE_SIZE RGB pixels from pixel memory into the line buffer, counts hs_valid results into output memory, and signals completion.
- Replaces the free-running file-driven stimulus with a restartable, stallable, abortable layer run.

---
 rtl/conv_layer_ctrl_if.sv | 47 ++++
 rtl/conv_layer_ctrl.sv | 121 ++++++++++++
 tb/tb_conv_layer_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_ctrl_if.sv
// Handshake/bus bundle between conv_layer_ctrl and the surrounding datapath.
// Optional perf counters appear when CONV_LAYER_CTRL_PERF_EN is defined.
interface conv_layer_ctrl_if #(
  parameter int WGT_ADDR_W = 5,
  parameter int PIX_ADDR_W = 16
);
  logic                  start;
  logic                  abort;
  logic                  out_stall;
  logic                  hs_valid;
  logic                  busy;
  logic                  done;
  logic                  err_overflow;
  logic                  wgt_rd_en;
  logic [WGT_ADDR_W-1:0] wgt_addr;
  logic                  wgt_load;
  logic [WGT_ADDR_W-1:0] wgt_load_idx;
  logic                  pix_rd_en;
  logic [PIX_ADDR_W-1:0] pix_addr;
  logic                  fifo_wr_en;
  logic                  out_wr_en;
  logic [PIX_ADDR_W-1:0] out_addr;
`ifdef CONV_LAYER_CTRL_PERF_EN
  logic [31:0]           perf_cycles;
  logic [31:0]           perf_stalls;
`endif

  // controller side
  modport master (
`ifdef CONV_LAYER_CTRL_PERF_EN
    output perf_cycles, output perf_stalls,
`endif
    input  start, abort, out_stall, hs_valid,
    output busy, done, err_overflow, wgt_rd_en, wgt_addr, wgt_load, wgt_load_idx,
    output pix_rd_en, pix_addr, fifo_wr_en, out_wr_en, out_addr
  );

  // datapath / environment side
  modport slave (
`ifdef CONV_LAYER_CTRL_PERF_EN
    input  perf_cycles, input perf_stalls,
`endif
    output start, abort, out_stall, hs_valid,
    input  busy, done, err_overflow, wgt_rd_en, wgt_addr, wgt_load, wgt_load_idx,
    input  pix_rd_en, pix_addr, fifo_wr_en, out_wr_en, out_addr
  );
endinterface

// File: rtl/conv_layer_ctrl.sv
// First-layer convolution sequencer: loads NUM_FILTERS weights + bias into the
// conv2d bank, streams the image into the line buffer, counts results out.
// Optional feature macro: CONV_LAYER_CTRL_PERF_EN (perf_cycles / perf_stalls).
module conv_layer_ctrl #(
  parameter int IMAGE_SIZE  = 224,
  parameter int OUT_SIZE    = 112,
  parameter int NUM_FILTERS = 16,
  parameter int PIX_ADDR_W  = 16,
  parameter int WGT_ADDR_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  conv_layer_ctrl_if.master  bus
);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;

  localparam logic [WGT_ADDR_W-1:0] WGT_LAST = WGT_ADDR_W'(NUM_FILTERS);
  localparam logic [PIX_ADDR_W-1:0] PIX_LAST = PIX_ADDR_W'(IMAGE_SIZE*IMAGE_SIZE-1);
  localparam logic [PIX_ADDR_W:0]   OUT_FULL = (PIX_ADDR_W+1)'(OUT_SIZE*OUT_SIZE);

  state_e                state_q;
  logic [WGT_ADDR_W-1:0] wgt_cnt_q;
  logic [PIX_ADDR_W-1:0] pix_cnt_q;
  logic [PIX_ADDR_W:0]   out_cnt_q;   // one spare bit so the full count is representable
  logic                  wgt_load_q;
  logic [WGT_ADDR_W-1:0] wgt_load_idx_q;
  logic                  fifo_wr_en_q;
  logic                  err_q;

  logic busy, start_go, wgt_rd_en, pix_rd_en, out_full, out_wr_en;

  // abort beats start in IDLE
  assign start_go  = (state_q == IDLE) && bus.start && !bus.abort;
  assign busy      = (state_q == LOAD_W) || (state_q == STREAM) || (state_q == DRAIN);
  assign wgt_rd_en = (state_q == LOAD_W);
  assign pix_rd_en = (state_q == STREAM) && !bus.out_stall;
  assign out_full  = (out_cnt_q >= OUT_FULL);
  assign out_wr_en = bus.hs_valid && busy && !out_full;

  assign bus.busy         = busy;
  assign bus.done         = (state_q == DONE);
  assign bus.err_overflow = err_q;
  assign bus.wgt_rd_en    = wgt_rd_en;
  assign bus.wgt_addr     = wgt_cnt_q;
  assign bus.wgt_load     = wgt_load_q;
  assign bus.wgt_load_idx = wgt_load_idx_q;
  assign bus.pix_rd_en    = pix_rd_en;
  assign bus.pix_addr     = pix_cnt_q;
  assign bus.fifo_wr_en   = fifo_wr_en_q;
  assign bus.out_wr_en    = out_wr_en;
  assign bus.out_addr     = out_cnt_q[PIX_ADDR_W-1:0];

  // Sequencer FSM, counters and the 1-cycle memory-latency strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      wgt_cnt_q      <= '0;
      pix_cnt_q      <= '0;
      out_cnt_q      <= '0;
      wgt_load_q     <= 1'b0;
      wgt_load_idx_q <= '0;
      fifo_wr_en_q   <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      // memory read data lands one cycle after the strobe, even across abort
      wgt_load_q     <= wgt_rd_en;
      wgt_load_idx_q <= wgt_cnt_q;
      fifo_wr_en_q   <= pix_rd_en;
      if (out_wr_en) out_cnt_q <= out_cnt_q + 1'b1;
      if (bus.hs_valid && (!busy || out_full)) err_q <= 1'b1;
      case (state_q)
        IDLE: if (start_go) begin
          state_q   <= LOAD_W;
          wgt_cnt_q <= '0;
          pix_cnt_q <= '0;
          out_cnt_q <= '0;
          err_q     <= 1'b0;
        end
        LOAD_W: begin
          if (bus.abort) state_q <= IDLE;
          else if (wgt_cnt_q == WGT_LAST) state_q <= STREAM;
          else wgt_cnt_q <= wgt_cnt_q + 1'b1;
        end
        STREAM: begin
          if (bus.abort) state_q <= IDLE;
          else if (pix_rd_en) begin
            if (pix_cnt_q == PIX_LAST) state_q <= DRAIN;
            else pix_cnt_q <= pix_cnt_q + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.abort) state_q <= IDLE;
          else if (out_full) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CONV_LAYER_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_stalls_q;
  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_stalls = perf_stalls_q;

  // Saturating busy/stall cycle counters, cleared when a run starts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else if (start_go) begin
      perf_cycles_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (busy && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 1'b1;
      if ((state_q == STREAM) && bus.out_stall && (perf_stalls_q != '1))
        perf_stalls_q <= perf_stalls_q + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_conv_layer_ctrl.sv
// Scoreboard bench for conv_layer_ctrl (8x8 image, 4x4 output, 16 filters).
// Stimulus pushes expected (cycle, value) events; a negedge monitor pops and compares.
module tb_conv_layer_ctrl;
  localparam int IS = 8, OS = 4, NF = 16, PAW = 16, WAW = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  conv_layer_ctrl_if #(.WGT_ADDR_W(WAW), .PIX_ADDR_W(PAW)) bus();

  conv_layer_ctrl #(
    .IMAGE_SIZE(IS), .OUT_SIZE(OS), .NUM_FILTERS(NF),
    .PIX_ADDR_W(PAW), .WGT_ADDR_W(WAW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {int c; int v;} ev_t;
  ev_t q_wrd[$], q_wld[$], q_pix[$], q_fifo[$], q_out[$], q_done[$];
  int errors = 0, checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic sb(input string nm, input bit have, input ev_t e, input int v);
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL %s: unexpected event value %0d at cycle %0d", nm, v, cyc);
    end else if (e.c != cyc || e.v != v) begin
      errors++;
      $display("FAIL %s: got value %0d at cycle %0d, expected value %0d at cycle %0d",
               nm, v, cyc, e.v, e.c);
    end
  endtask

  // monitor: every asserted strobe must match the head of its queue
  always @(negedge clk) begin
    ev_t e;
    bit  h;
    e = '{0, 0};
    if (bus.wgt_rd_en) begin
      h = q_wrd.size() > 0; if (h) e = q_wrd.pop_front();
      sb("wgt_rd", h, e, int'(bus.wgt_addr));
    end
    if (bus.wgt_load) begin
      h = q_wld.size() > 0; if (h) e = q_wld.pop_front();
      sb("wgt_load", h, e, int'(bus.wgt_load_idx));
    end
    if (bus.pix_rd_en) begin
      h = q_pix.size() > 0; if (h) e = q_pix.pop_front();
      sb("pix_rd", h, e, int'(bus.pix_addr));
    end
    if (bus.fifo_wr_en) begin
      h = q_fifo.size() > 0; if (h) e = q_fifo.pop_front();
      sb("fifo_wr", h, e, 0);
    end
    if (bus.out_wr_en) begin
      h = q_out.size() > 0; if (h) e = q_out.pop_front();
      sb("out_wr", h, e, int'(bus.out_addr));
    end
    if (bus.done) begin
      h = q_done.size() > 0; if (h) e = q_done.pop_front();
      sb("done", h, e, 0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_wgt_rd"}, int'(bus.wgt_rd_en), 0);
    chk({tag, "_wgt_load"}, int'(bus.wgt_load), 0);
    chk({tag, "_pix_rd"}, int'(bus.pix_rd_en), 0);
    chk({tag, "_fifo_wr"}, int'(bus.fifo_wr_en), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_err"}, int'(bus.err_overflow), 0);
    chk({tag, "_out_wr"}, int'(bus.out_wr_en), 0);
  endtask

  // One layer run. stall_p: pixel index where a 3-cycle stall starts (-1 none).
  // abort_p: pixel index on whose issue cycle abort is pulsed (-1 none).
  // hs_late: last result lands in DRAIN and the extra result arrives in IDLE;
  // otherwise all results land in STREAM and the extra one arrives while busy.
  task automatic run(input int stall_p, input int abort_p, input bit hs_late);
    int c, cs, last, dc, endc, n, pc;
    int hs[$];
    c = cyc;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int a = 0; a <= NF; a++) begin
      q_wrd.push_back('{c + 1 + a, a});
      q_wld.push_back('{c + 2 + a, a});
    end
    cs   = c + NF + 2;
    n    = (abort_p >= 0) ? abort_p + 1 : IS * IS;
    last = cs;
    for (int p = 0; p < n; p++) begin
      pc = cs + p + ((stall_p >= 0 && p >= stall_p) ? 3 : 0);
      q_pix.push_back('{pc, p});
      q_fifo.push_back('{pc + 1, 0});
      last = pc;
    end
    dc = 0;
    if (abort_p < 0) begin
      if (hs_late) begin
        for (int k = 0; k < 15; k++) hs.push_back(cs + 2 + 2 * k);
        hs.push_back(last + 1);
        dc = last + 3;
        hs.push_back(dc + 2);
      end else begin
        for (int k = 0; k < 16; k++) hs.push_back(cs + 2 + 2 * k);
        hs.push_back(cs + 34);
        dc = last + 2;
      end
      for (int k = 0; k < 16; k++) q_out.push_back('{hs[k], k});
      q_done.push_back('{dc, 0});
      endc = dc + 3;
    end else endc = last + 3;

    for (int t = c + 1; t <= endc; t++) begin
      if (t == c + 1) begin
        chk("busy_load", int'(bus.busy), 1);
        chk("err_cleared", int'(bus.err_overflow), 0);
      end
      if (abort_p < 0 && t == dc - 1) chk("busy_drain", int'(bus.busy), 1);
      if (abort_p < 0 && t == dc) begin
        chk("busy_done", int'(bus.busy), 0);
        chk("err_at_done", int'(bus.err_overflow), hs_late ? 0 : 1);
      end
      if (abort_p >= 0 && t == last + 1) chk("busy_abort", int'(bus.busy), 0);
      bus.start     = (t == c + 3);   // must be ignored while busy
      bus.out_stall = (stall_p >= 0) && (t >= cs + stall_p) && (t < cs + stall_p + 3);
      bus.abort     = (abort_p >= 0) && (t == last);
      bus.hs_valid  = (hs.size() > 0) && (hs[0] == t);
      if (bus.hs_valid) void'(hs.pop_front());
      step();
    end
    bus.start = 1'b0; bus.out_stall = 1'b0; bus.abort = 1'b0; bus.hs_valid = 1'b0;
    chk("err_end", int'(bus.err_overflow), (abort_p < 0) ? 1 : 0);
`ifdef CONV_LAYER_CTRL_PERF_EN
    chk("perf_cycles", int'(bus.perf_cycles), (abort_p < 0) ? dc - c - 1 : last - c);
    chk("perf_stalls", int'(bus.perf_stalls), (stall_p >= 0) ? 3 : 0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    bus.start = 1'b0; bus.abort = 1'b0; bus.out_stall = 1'b0; bus.hs_valid = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // stalled run, last result in DRAIN, overflow pulse in IDLE
    run(10, -1, 1);
    step();
    chk("err_sticky", int'(bus.err_overflow), 1);

    // abort on pixel 20
    run(-1, 20, 0);

    // start and abort together in IDLE: stays idle
    bus.start = 1'b1; bus.abort = 1'b1; step();
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("start_abort_idle", int'(bus.busy), 0);
    step();

    // restart after abort: all results in STREAM, overflow while busy
    run(-1, -1, 0);
    step();

    // async reset in the middle of LOAD_W
    c = cyc;
    bus.start = 1'b1; step(); bus.start = 1'b0;
    for (int a = 0; a <= 4; a++) q_wrd.push_back('{c + 1 + a, a});
    for (int a = 0; a <= 3; a++) q_wld.push_back('{c + 2 + a, a});
    repeat (4) step();
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    chk("async_rst_wgt_addr", int'(bus.wgt_addr), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // full run after reset release
    run(5, -1, 0);
    repeat (3) step();

    chk("left_wgt_rd", q_wrd.size(), 0);
    chk("left_wgt_load", q_wld.size(), 0);
    chk("left_pix_rd", q_pix.size(), 0);
    chk("left_fifo_wr", q_fifo.size(), 0);
    chk("left_out_wr", q_out.size(), 0);
    chk("left_done", q_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
